// File: rtl/dcpu_pkg.sv
// rtl/dcpu_pkg.sv - shared width, IO map, CTRL bit positions and FSM encoding for the DCPU memory controller
package dcpu_pkg;

  localparam int DCPU_W = 16;

  localparam logic [DCPU_W-1:0] IO_TIMER_CNT = 16'hFFF0;
  localparam logic [DCPU_W-1:0] IO_TIMER_CMP = 16'hFFF1;
  localparam logic [DCPU_W-1:0] IO_CTRL      = 16'hFFF2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    REG_CNT  = 2'd0,
    REG_CMP  = 2'd1,
    REG_CTRL = 2'd2
  } timer_reg_t;

endpackage

// File: rtl/dcpu_timer.sv
// rtl/dcpu_timer.sv - free-running compare timer with W1C pending flag and register port
module dcpu_timer
  import dcpu_pkg::*;
#(
  parameter int W = DCPU_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         we,
  input  timer_reg_t   sel,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         irq
);

  logic [W-1:0] cnt;
  logic [W-1:0] cmp;
  logic         en;
  logic         pend;
  logic         match;
  logic         wr_cnt;
  logic         wr_cmp;
  logic         wr_ctrl;

  assign wr_cnt  = we && (sel == REG_CNT);
  assign wr_cmp  = we && (sel == REG_CMP);
  assign wr_ctrl = we && (sel == REG_CTRL);
  assign match   = en && (cnt == cmp);

  // CPU writes to CNT beat the reload; a compare hit beats the W1C clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt  <= '0;
      cmp  <= '1;
      en   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (wr_cnt) cnt <= wdata;
      else if (match) cnt <= '0;
      else if (en) cnt <= cnt + W'(1);

      if (wr_cmp) cmp <= wdata;
      if (wr_ctrl) en <= wdata[CTRL_EN];

      if (match) pend <= 1'b1;
      else if (wr_ctrl && wdata[CTRL_PEND]) pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CNT:  rdata = cnt;
      REG_CMP:  rdata = cmp;
      REG_CTRL: begin
        rdata[CTRL_EN]   = en;
        rdata[CTRL_PEND] = pend;
      end
      default:  rdata = '0;
    endcase
  end

  assign irq = pend;

endmodule

// File: rtl/dcpu_memctl.sv
// rtl/dcpu_memctl.sv - DCPU bus slave: wait-stated RAM plus memory-mapped timer
module dcpu_memctl
  import dcpu_pkg::*;
#(
  parameter int W    = DCPU_W,
  parameter int AW   = 12,
  parameter int WAIT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_irq
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT);

  mem_state_t   state;
  mem_state_t   state_next;
  logic [3:0]   wait_cnt;
  logic [W-1:0] addr_q;
  logic [W-1:0] dat_q;
  logic         we_q;

  logic [W-1:0] ram [0:(2**AW)-1];
  logic [W-1:0] ram_rd;
  logic [AW-1:0] rd_idx;
  logic         ram_we;

  logic         is_ram;
  logic         io_hit;
  timer_reg_t   tsel;
  logic         tm_we;
  logic [W-1:0] tm_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && i_cs) begin
        addr_q   <= i_addr;
        dat_q    <= i_dat;
        we_q     <= i_we;
        wait_cnt <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_cs) state_next = (WAIT_INIT == 4'd0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd1) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign is_ram = ~addr_q[W-1];

  always_comb begin
    io_hit = 1'b1;
    tsel   = REG_CNT;
    case (addr_q)
      IO_TIMER_CNT: tsel = REG_CNT;
      IO_TIMER_CMP: tsel = REG_CMP;
      IO_CTRL:      tsel = REG_CTRL;
      default:      io_hit = 1'b0;
    endcase
  end

  assign ram_we = (state == ST_ACK) && we_q && is_ram && !i_reset;
  assign tm_we  = (state == ST_ACK) && we_q && io_hit;

  // With WAIT=0 the read launches from the live address in the sampling cycle.
  assign rd_idx = (state == ST_IDLE) ? i_addr[AW-1:0] : addr_q[AW-1:0];

  always_ff @(posedge i_clk) begin
    if (ram_we) ram[addr_q[AW-1:0]] <= dat_q;
    ram_rd <= ram[rd_idx];
  end

  dcpu_timer #(.W(W)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .we      (tm_we),
    .sel     (tsel),
    .wdata   (dat_q),
    .rdata   (tm_rdata),
    .irq     (o_irq)
  );

  assign o_ack = (state == ST_ACK);

  always_comb begin
    o_dat = '0;
    if (state == ST_ACK) begin
      if (is_ram) o_dat = ram_rd;
      else if (io_hit) o_dat = tm_rdata;
    end
  end

endmodule

// File: tb/tb_dcpu_memctl.sv
// tb/tb_dcpu_memctl.sv - self-checking bench for dcpu_memctl with WAIT=1 and WAIT=0 instances
module tb_dcpu_memctl;

  logic        clk;
  logic        rst;
  logic        cs   [2];
  logic        we   [2];
  logic [15:0] addr [2];
  logic [15:0] wdat [2];
  logic [15:0] rdat [2];
  logic        ack  [2];
  logic        irq  [2];

  int checks;
  int errors;

  typedef struct {
    logic [15:0] dat;
    logic        chk;
    int          lat;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic        chk;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [19];

  dcpu_memctl #(.W(16), .AW(12), .WAIT(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_cs(cs[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_dat(wdat[0]), .o_dat(rdat[0]), .o_ack(ack[0]), .o_irq(irq[0])
  );

  dcpu_memctl #(.W(16), .AW(12), .WAIT(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_cs(cs[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_dat(wdat[1]), .o_dat(rdat[1]), .o_ack(ack[1]), .o_irq(irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus transaction; inputs are scrambled while waiting since only latched values count.
  task automatic xfer(input string tag, input int d, input logic w, input logic [15:0] a,
                      input logic [15:0] wd, input logic chk, input logic [15:0] exp);
    sb_t e;
    int  n;
    bit  got;
    @(negedge clk);
    check({tag, "_idle_ack"}, ack[d], 0);
    e.dat = exp;
    e.chk = chk;
    e.lat = (d == 0) ? 1 : 2;
    sbq.push_back(e);
    cs[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = wd;
    got = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack[d]) begin
        got = 1;
        break;
      end
      addr[d] = 16'($urandom);
      wdat[d] = 16'($urandom);
      we[d]   = 1'($urandom);
    end
    e = sbq.pop_front();
    if (!got) n = -1;
    check({tag, "_lat"}, n, e.lat);
    if (got && e.chk) check({tag, "_dat"}, rdat[d], e.dat);
    cs[d] = 1'b0; we[d] = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 0; we[d] = 0; addr[d] = 0; wdat[d] = 0;
    end

    tbl[0]  = '{1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0000};
    tbl[1]  = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'hFFFF};
    tbl[2]  = '{1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234};
    tbl[5]  = '{1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 16'h0FFF, 16'h0ABC, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h0ABC};
    tbl[8]  = '{1'b0, 16'h1010, 16'h0000, 1'b1, 16'h1234};
    tbl[9]  = '{1'b1, 16'h0000, 16'h1111, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 16'h8000, 16'h5555, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000};
    tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
    tbl[13] = '{1'b0, 16'hFFF3, 16'h0000, 1'b1, 16'h0000};
    tbl[14] = '{1'b1, 16'hFFF1, 16'h0040, 1'b0, 16'h0000};
    tbl[15] = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'h0040};
    tbl[16] = '{1'b1, 16'h8000, 16'h7777, 1'b0, 16'h0000};
    tbl[17] = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'h0040};
    tbl[18] = '{1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h0000};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ack%0d", d), ack[d], 0);
      check($sformatf("rst_dat%0d", d), rdat[d], 0);
      check($sformatf("rst_irq%0d", d), irq[d], 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 19; i++)
      xfer($sformatf("vec%0d", i), 1, tbl[i].we, tbl[i].addr, tbl[i].wdat, tbl[i].chk, tbl[i].exp);

    // WAIT=0 with the request held: acks on alternate cycles only
    @(negedge clk);
    cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0001; wdat[0] = 16'h0077;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d", c), ack[0], (c % 2 == 1) ? 1 : 0);
      if (c == 5) begin
        cs[0] = 1'b0; we[0] = 1'b0;
      end
    end
    xfer("w0_rd", 0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0077);

    // Timer compare, W1C and EN behaviour
    xfer("t_cmp", 1, 1'b1, 16'hFFF1, 16'h0005, 1'b0, 16'h0000);
    xfer("t_en", 1, 1'b1, 16'hFFF2, 16'h0001, 1'b0, 16'h0000);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (irq[1]) break;
    end
    check("irq_delay", n, 7);
    xfer("t_cnt_wrap", 1, 1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0003);
    xfer("t_w1c", 1, 1'b1, 16'hFFF2, 16'h0003, 1'b0, 16'h0000);
    @(negedge clk);
    check("irq_cleared", irq[1], 0);
    xfer("t_ctrl_rd", 1, 1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h0001);
    xfer("t_dis", 1, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 16'h0000);
    xfer("t_ctrl_off", 1, 1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h0000);

    // CPU write to CNT lands on the same edge as a compare match
    xfer("p_cmp", 1, 1'b1, 16'hFFF1, 16'h0010, 1'b0, 16'h0000);
    xfer("p_cnt", 1, 1'b1, 16'hFFF0, 16'h000E, 1'b0, 16'h0000);
    xfer("p_en", 1, 1'b1, 16'hFFF2, 16'h0001, 1'b0, 16'h0000);
    xfer("p_wr", 1, 1'b1, 16'hFFF0, 16'h0100, 1'b0, 16'h0000);
    check("prio_irq_before", irq[1], 0);
    @(negedge clk);
    check("prio_irq_after", irq[1], 1);
    xfer("p_rd", 1, 1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0103);

    // Reset while a write sits in WAIT
    @(negedge clk);
    cs[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0020; wdat[1] = 16'hBEEF;
    @(negedge clk);
    check("mid_wait_ack", ack[1], 0);
    rst = 1'b1; cs[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", ack[1], 0);
    check("mid_rst_dat", rdat[1], 0);
    check("mid_rst_irq", irq[1], 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_noack%0d", c), ack[1], 0);
    end
    xfer("r_ram", 1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h2222);
    xfer("r_cmp", 1, 1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'hFFFF);
    xfer("r_cnt", 1, 1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0000);
    xfer("r_ctrl", 1, 1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcpu_memctl.md
DCPU_MEMCTL -- requirements
Module: dcpu_memctl

Interface
REQ-001 SHALL have parameter W, default 16: data and address width.
REQ-002 SHALL have parameter AW, default 12: RAM index width, giving 2^AW words.
REQ-003 SHALL have parameter WAIT, default 1: wait cycles per access, legal range 0..15.
REQ-004 SHALL have port i_clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_cs  in  1  CPU bus request; held by the CPU until o_ack.
REQ-007 SHALL have port i_we  in  1  write strobe, qualified by i_cs.
REQ-008 SHALL have port i_addr  in  W  word address.
REQ-009 SHALL have port i_dat  in  W  write data.
REQ-010 SHALL have port o_dat  out  W  read data, valid only while o_ack=1.
REQ-011 SHALL have port o_ack  out  1  one-cycle transfer-complete pulse.
REQ-012 SHALL have port o_irq  out  1  timer interrupt, wired to CPU i_irq.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> ACK -> IDLE.
- IDLE: on i_cs=1, latch i_addr, i_dat and i_we; go to WAIT with counter=WAIT, or directly to ACK when WAIT=0.
REQ-014 SHALL decrement the counter in WAIT and go to ACK when it reaches 0, so o_ack rises WAIT+1 cycles after the i_cs sample.
REQ-015 SHALL assert o_ack for exactly one cycle in ACK and return to IDLE.
- A request still high in IDLE after ACK starts a new transaction; no ack in back-to-back cycles.
REQ-016 SHALL ignore i_cs, i_we, i_addr and i_dat changes outside IDLE; the latched values govern the transaction.
REQ-017 SHALL decode the latched address as follows.
- addr[W-1]=0: RAM, index addr[AW-1:0]; upper bits alias.
- 0xFFF0: TIMER_CNT.
- 0xFFF1: TIMER_CMP.
- 0xFFF2: CTRL, bit0=EN, bit1=PEND.
- Any other address: read 0, write ignored, still acked.
REQ-018 SHALL perform RAM and register writes in the ACK cycle only, once per transaction.
REQ-019 SHALL drive o_dat with RAM or register read data in ACK and 0 otherwise.
- RAM reads use a registered read launched before ACK.
REQ-020 SHALL read CTRL as {14'b0, PEND, EN}.
- A CTRL write sets EN from bit0; bit1=1 clears PEND (write-one-to-clear).
REQ-021 SHALL increment TIMER_CNT by 1 each cycle while EN=1.
- When CNT==CMP, set PEND and load CNT=0 on the next edge.
- 0xFFFF+1 wraps to 0.
REQ-022 SHALL give a CPU write to TIMER_CNT priority over increment and compare-reload in the same cycle.
REQ-023 SHALL let a compare-set of PEND win over a simultaneous W1C clear.
REQ-024 SHALL drive o_irq = PEND, registered.

Reset
REQ-025 SHALL on i_reset go to IDLE with o_ack=0, o_dat=0, CNT=0, CMP=0xFFFF, EN=0, PEND=0, o_irq=0.
REQ-026 SHALL on reset mid-transaction abandon it: no ack, no write; RAM contents are not reset.
REQ-027 SHALL give i_reset priority over every other event in the same cycle.

Structure
REQ-028 SHALL take W, the IO addresses 0xFFF0-0xFFF2, the CTRL bit positions and the FSM state encoding from shared package dcpu_pkg.
REQ-029 SHALL place the timer (CNT, CMP, EN, PEND, compare logic) in sub-module dcpu_timer with a register-write/read port; RAM, FSM and decode stay in dcpu_memctl.

Verification
REQ-030 SHALL cover, with WAIT=1: write 0x1234 to 0x0010, then read 0x0010 -> o_ack 2 cycles after each i_cs, read o_dat=0x1234.
REQ-031 SHALL cover, with WAIT=0 and i_cs held high for 3 transactions -> acks on cycles 1, 3, 5, never adjacent.
REQ-032 SHALL cover: write CMP=5, CTRL=1 -> o_irq=1 about 6 cycles later, CNT reads back small after wrap; write CTRL=0x3 -> o_irq=0 next cycle, EN stays 1.
REQ-033 SHALL cover: read 0x8000 -> o_dat=0 with ack; write 0x8000 -> no RAM or register change.
REQ-034 SHALL cover: i_reset in WAIT during a write of 0xBEEF to 0x0020 -> no ack, RAM[0x20] unchanged, next request served normally.
REQ-035 SHALL cover: CPU write CNT=0x0100 in the same cycle as a compare match -> CNT=0x0100, PEND=1.
